axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- AXI3-style slave memory model; the responder end of the core's AXI master interface.
- Sits in the simulation top and connects directly to the core's ar/r/aw/w/b channels.
- Services one read burst and one write burst concurrently, on independent channels, from a word-addressed SRAM array.
- Provides configurable read latency, so the bridge and caches are exercised under realistic timing.

Parameters:
- ADDR_W, 16, log2 of the number of 32-bit words in the array; word index = addr[ADDR_W+1:2].
- RD_LAT, 2, extra idle cycles between AR acceptance and the first rvalid (0..15).
- INIT_FILE, "", hex file loaded with $readmemh at time 0 when non-empty.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- arid  in  4  read ID
- araddr  in  32  read start byte address
- arlen  in  8  beats minus 1
- arsize  in  3  log2 of bytes per beat (0..2)
- arburst  in  2  00 FIXED, 01 INCR, others treated as INCR
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rid  out  4  read ID echo
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awid  in  4  write ID
- awaddr  in  32  write start byte address
- awlen  in  8  beats minus 1
- awsize  in  3  log2 of bytes per beat
- awburst  in  2  same encoding as arburst
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wid  in  4  write data ID (ignored)
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wlast  in  1  last write beat
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bid  out  4  write response ID
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Reset values:
  - arready=1, awready=1.
  - rvalid=0, wready=0, bvalid=0, rlast=0.
  - rid=0, rdata=0, rresp=0, bid=0, bresp=0.
  - FSMs return to IDLE.
  - Array contents are not affected by reset.
  - Reset mid-burst aborts the burst silently; no further beats or responses are issued.
- Handshakes:
  - A transfer occurs on a rising edge with valid&ready.
  - Outputs are registered and held stable while valid=1 and ready=0.
- Read FSM, states R_IDLE, R_WAIT, R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch id, addr, len, size and burst; clear beat counter; go to R_WAIT, or to R_DATA if RD_LAT=0.
  - R_WAIT: arready=0; count RD_LAT cycles, then go to R_DATA. First rvalid appears RD_LAT+1 cycles after the AR handshake edge.
  - R_DATA:
    - rvalid=1; rdata = mem[addr index] as a full aligned word; rid = latched id; rresp = 00.
    - rlast=1 when beat counter == len.
    - On each accepted beat: counter+1; addr += (1<<size) for INCR, unchanged for FIXED.
    - After the last beat is accepted, go to R_IDLE; arready rises on the next cycle (no same-cycle re-accept).
  - Address wraps modulo 2^(ADDR_W+2).
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1, wready=0. On AW handshake, latch fields and go to W_DATA.
  - W_DATA:
    - wready=1. Each accepted beat writes the bytes of wdata whose wstrb bit is set; addr advances as for reads.
    - The burst ends on the beat where counter == len; go to W_RESP.
    - If wlast differs from (counter == len) on any accepted beat, set a sticky error, so bresp=10.
  - W_RESP: bvalid=1, bid = latched id, bresp = 00 or 10. On bready, go to W_IDLE and clear the error.
  - W beats presented before the AW handshake are not accepted (wready=0).
- Same-word collision: a read beat sampled in the same cycle as a write to that word returns the pre-write data; the write lands in the array.
- len=0 (single beat): rlast=1 on the first beat; a write goes to W_RESP after one beat.

Optional Feature:
- Macro AXI_SLAVE_ERRRESP_EN.
- When defined: a beat whose address is ≥ 2^(ADDR_W+2) returns rresp=10 with rdata=0, drops its write, and forces bresp=10.
- When undefined: the address wraps modulo the array size and the response is always 00, except for the wlast-mismatch error.

Test Plan:
- RD_LAT=2, mem[4]=0x11223344, single read araddr=0x10 arlen=0 arid=3 → rvalid 3 cycles after the AR edge, rdata=0x11223344, rid=3, rlast=1, rresp=00.
- INCR read arlen=3 from 0x20 with rready toggling 1,0,1,0 → 4 beats mem[8..11] in order, rdata stable while stalled, rlast on beat 4 only, arready low until the cycle after the last beat.
- Write awaddr=0x40 awlen=0 wdata=0xAABBCCDD wstrb=0101 over 0xFFFFFFFF → word becomes 0xFFBBFFDD; bvalid with bid=awid, bresp=00; held until bready.
- Write awlen=1 with wlast=1 on beat 1 → bresp=10 after beat 2; both beats are written.
- Concurrent read burst (arlen=3) and write burst (awlen=3) on disjoint addresses → both complete with correct data, with no cross-channel stall.
- Reset asserted during R_DATA beat 2 → next cycle rvalid=0 and arready=1; a new read then completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3-style SRAM slave model with independent read and write burst engines.
// Optional macro AXI_SLAVE_ERRRESP_EN: out-of-range beats return SLVERR instead of wrapping.
module axi_sram_slave #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RD_LAT    = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [WORDS];

  // Write IDs are not checked; W beats are matched to the single open AW burst.
  logic unused_wid;
  assign unused_wid = ^wid;

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [1:0] bt);
    return (bt == 2'b00) ? a : a + (32'd1 << sz);
  endfunction

  // ---------------- read channel ----------------
  r_state_t    r_state, r_next;
  logic [3:0]  r_id;
  logic [31:0] r_addr, rd_addr;
  logic [7:0]  r_len, r_cnt, rd_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_wait;
  logic        r_oob;

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = (RD_LAT == 0) ? R_DATA : R_WAIT;
      end
      R_WAIT: if (r_wait == 4'(RD_LAT - 1)) r_next = R_DATA;
      R_DATA: if (rvalid && rready && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Address/count of the beat loaded into the output registers this edge:
  // the latched start on the first beat, the stepped one thereafter.
  always_comb begin
    rd_addr = rvalid ? step_addr(r_addr, r_size, r_burst) : r_addr;
    rd_cnt  = rvalid ? r_cnt + 8'd1 : r_cnt;
`ifdef AXI_SLAVE_ERRRESP_EN
    r_oob   = |rd_addr[31:ADDR_W+2];
`else
    r_oob   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: if (arvalid) begin
          r_id    <= arid;
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= '0;
          r_wait  <= '0;
        end
        R_WAIT: r_wait <= r_wait + 4'd1;
        R_DATA: begin
          if (!rvalid || (rready && !rlast)) begin
            r_addr <= rd_addr;
            r_cnt  <= rd_cnt;
            rvalid <= 1'b1;
            rid    <= r_id;
            rlast  <= (rd_cnt == r_len);
            rresp  <= r_oob ? 2'b10 : 2'b00;
            rdata  <= r_oob ? '0 : mem[rd_addr[ADDR_W+1:2]];
          end else if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- write channel ----------------
  w_state_t    w_state, w_next;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err, w_oob, w_final, beat_err;

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_final  = (w_cnt == w_len);
`ifdef AXI_SLAVE_ERRRESP_EN
    w_oob    = |w_addr[31:ADDR_W+2];
`else
    w_oob    = 1'b0;
`endif
    beat_err = (wlast != w_final) || w_oob;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: if (awvalid) begin
          w_id    <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_cnt   <= '0;
          w_err   <= 1'b0;
        end
        W_DATA: if (wvalid) begin
          w_addr <= step_addr(w_addr, w_size, w_burst);
          w_cnt  <= w_cnt + 8'd1;
          w_err  <= w_err | beat_err;
          if (w_final) begin
            bid   <= w_id;
            bresp <= (w_err || beat_err) ? 2'b10 : 2'b00;
          end
        end
        W_RESP: if (bready) w_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // Array has no reset; a read sampled on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (!reset && w_state == W_DATA && wvalid && !w_oob) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_addr[ADDR_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
